// File: rtl/ed25519_addsub_modp_pipe.sv
// Pipelined add/sub modulo P (default 2^255-19) with valid/ready on both sides and metadata passthrough.
// Define ED25519_ADDSUB_FULL_REDUCE_EN to add a third stage that makes every output canonical.
module ed25519_addsub_modp_pipe #(
    parameter int W = 255,
    parameter int M = 128,
    parameter logic [W-1:0] P = W'(256'h7FFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFED)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_valid,
    output logic         i_ready,
    input  logic         i_sub,
    input  logic [W-1:0] in0,
    input  logic [W-1:0] in1,
    input  logic [M-1:0] m_i,
    output logic         o_valid,
    input  logic         o_ready,
    output logic [W-1:0] out0,
    output logic [M-1:0] m_o
);

    localparam logic [W:0] P1 = {1'b0, P};
    localparam logic [W:0] P2 = {P, 1'b0};

    logic         s1_ready;
    logic         s2_ready;
    logic         v1_reg;
    logic         sub1_reg;
    logic [W:0]   raw1_reg;
    logic [W:0]   raw_next;
    logic [M-1:0] m1_reg;
    logic         v2_reg;
    logic [W-1:0] r2_reg;
    logic [W-1:0] r2_next;
    logic [M-1:0] m2_reg;
    logic [W:0]   fold_sum;

    // For sub, bit W of raw is the carry-out: 1 means no borrow (a >= b).
    always_comb begin
        if (i_sub) begin
            raw_next = {1'b0, in0} + {1'b0, ~in1} + (W+1)'(1);
        end else begin
            raw_next = {1'b0, in0} + {1'b0, in1};
        end
    end

    // The 2P branches only fire for non-canonical operands; they keep the result
    // congruent mod P while still fitting in W bits.
    always_comb begin
        fold_sum = {1'b0, raw1_reg[W-1:0]} + P1;
        r2_next  = raw1_reg[W-1:0];
        if (!sub1_reg) begin
            if (raw1_reg >= P2) begin
                r2_next = W'(raw1_reg - P2);
            end else if (raw1_reg >= P1) begin
                r2_next = W'(raw1_reg - P1);
            end
        end else if (!raw1_reg[W]) begin
            if (fold_sum[W]) begin
                r2_next = fold_sum[W-1:0];
            end else begin
                r2_next = W'({1'b0, raw1_reg[W-1:0]} + P2);
            end
        end
    end

    assign s1_ready = !v1_reg || s2_ready;
    assign i_ready  = s1_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            v1_reg <= 1'b0;
        end else if (s1_ready) begin
            v1_reg <= i_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (i_valid && s1_ready) begin
            raw1_reg <= raw_next;
            sub1_reg <= i_sub;
            m1_reg   <= m_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v2_reg <= 1'b0;
            r2_reg <= '0;
            m2_reg <= '0;
        end else if (s2_ready) begin
            v2_reg <= v1_reg;
            if (v1_reg) begin
                r2_reg <= r2_next;
                m2_reg <= m1_reg;
            end
        end
    end

`ifdef ED25519_ADDSUB_FULL_REDUCE_EN
    logic         s3_ready;
    logic         v3_reg;
    logic [W-1:0] r3_reg;
    logic [M-1:0] m3_reg;

    assign s3_ready = !v3_reg || o_ready;
    assign s2_ready = !v2_reg || s3_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            v3_reg <= 1'b0;
            r3_reg <= '0;
            m3_reg <= '0;
        end else if (s3_ready) begin
            v3_reg <= v2_reg;
            if (v2_reg) begin
                r3_reg <= (r2_reg >= P) ? (r2_reg - P) : r2_reg;
                m3_reg <= m2_reg;
            end
        end
    end

    assign o_valid = v3_reg;
    assign out0    = r3_reg;
    assign m_o     = m3_reg;
`else
    assign s2_ready = !v2_reg || o_ready;
    assign o_valid  = v2_reg;
    assign out0     = r2_reg;
    assign m_o      = m2_reg;
`endif

endmodule
